seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Parametrised seven-segment scan controller for the board's multiplexed hex display: the next generation of the fixed 8-digit scanner. It adds a configurable digit count and scan rate, anti-ghosting dead time, per-digit blanking and blinking, and tear-free number updates through a valid/ready handshake. It sits between the game logic's debug/score word and the `dpy_digit`/`dpy_segment` pins.

## Interface
- `DIGIT_CNT`, 8 — number of digits scanned, 1..16.
- `SCAN_DIV`, 100000 — clock cycles each digit is selected. Requires ≥ 2.
- `DEAD_CYC`, 500 — cycles at the start of each digit slot with segments forced off. Requires < `SCAN_DIV`.
- `BLINK_DIV`, 64 — number of frames per blink half-period. Requires ≥ 1.

- `clock`, in, 1 — system clock.
- `reset_n`, in, 1 — synchronous, active-low reset.
- `update_valid`, in, 1 — new `number`/`dp` is offered.
- `update_ready`, out, 1 — controller can accept an update.
- `number`, in, 4*`DIGIT_CNT` — hex nibbles; digit i is `number[4i+3:4i]`.
- `dp`, in, `DIGIT_CNT` — decimal point per digit, captured with `number`.
- `blank_mask`, in, `DIGIT_CNT` — 1 = digit always dark. Live, not handshaken.
- `blink_mask`, in, `DIGIT_CNT` — 1 = digit dark during the blink off-phase. Live.
- `digit_sel`, out, `DIGIT_CNT` — one-hot, active-high digit select.
- `segment`, out, 8 — [6:0] = g..a, [7] = dp, active high.

## Operation
- Registers:
  - scan counter `sc`: `$clog2(SCAN_DIV)` bits, 0..`SCAN_DIV`-1.
  - digit index `di`: 0..`DIGIT_CNT`-1.
  - blink frame counter `bc`: 0..`BLINK_DIV`-1.
  - blink phase `bp`: 0 = on, 1 = off.
  - shadow and active copies of `number`/`dp`.
  - `pending` flag.
- Counter advance:
  - `sc` increments every cycle.
  - When `sc` = `SCAN_DIV`-1: `sc` wraps to 0 and `di` advances, wrapping to 0 after `DIGIT_CNT`-1.
- Frame boundary: the cycle with `sc` = `SCAN_DIV`-1 and `di` = `DIGIT_CNT`-1.
  - If `pending`: active ← shadow, `pending` ← 0.
  - `bc` increments. At `BLINK_DIV`-1 it wraps to 0 and `bp` toggles.
- Handshake:
  - `update_ready` = ~`pending`, registered.
  - Accept on `update_valid & update_ready`: shadow ← {`number`, `dp`}, `pending` ← 1.
  - `update_valid` may drop without an accept; nothing is captured.
- Digit is dark when any of these holds: `sc` < `DEAD_CYC`; `blank_mask[di]`; `blink_mask[di] & bp`; or the leading-zero rule (Configuration) applies.
- Decode (segment[6:0]): 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71. segment[7] = active `dp[di]`.
- Dark digit: `segment` = 0; `digit_sel` stays one-hot.

## Timing
- While `reset_n` = 0 at an edge, all outputs and state clear:
  - `digit_sel` = 0, `segment` = 0, `update_ready` = 0.
  - active = 0, shadow = 0, `pending` = 0.
  - `sc` = `di` = `bc` = `bp` = 0.
- First cycle after release:
  - `digit_sel` = one-hot(0) and `segment` = 0 (dead time).
  - `update_ready` = 1.
- Outputs are registered, so they reflect `sc`/`di` with 1-cycle latency.
- An accept in cycle t gives `update_ready` = 0 from t+1.
  - Commit happens at the first frame boundary at or after t+1.
  - If t itself is a boundary cycle, commit waits one full frame.
  - The new value shows from digit 0's slot; `update_ready` = 1 the cycle after commit.
- Reset asserted mid-frame or with `pending` = 1 discards the shadow; there is no partial commit.
- `blank_mask` / `blink_mask` changes take effect on the next output register update (1 cycle).
- `DIGIT_CNT` = 1: every slot wrap is a frame boundary.

## Configuration
- `SEG_SCAN_LZB_EN`: leading-zero blanking.
  - Defined: digits above the most significant non-zero nibble of the active number are dark, unless that digit's `dp` = 1. Digit 0 is never blanked by this rule (all zeros shows a single "0").
  - Undefined: all digits display, and the rule is removed from the dark condition.

## Test plan
Parameters for all scenarios: `DIGIT_CNT`=4, `SCAN_DIV`=8, `DEAD_CYC`=2, `BLINK_DIV`=2.

1. Reset, then release, with active = 0.
   - `digit_sel` cycles 1→2→4→8 every 8 cycles.
   - `segment` = 00 for 2 cycles, then 3F for 6 cycles, in each slot.
2. Accept `number`=16'hF821 mid-frame.
   - `update_ready` = 0 until the frame boundary.
   - Next frame shows 06, 5B, 7F, 71 on digits 0..3; `update_ready` returns to 1.
3. Hold `update_valid` = 1 continuously with changing `number`.
   - Exactly one accept per frame; no digit of any frame mixes two values.
4. `blink_mask`=4'b0010, `blank_mask`=4'b1000.
   - Digit 3 is always 00.
   - Digit 1 alternates lit/dark every 2 frames.
5. With `SEG_SCAN_LZB_EN` defined, `number`=16'h0050, `dp`=4'b1000.
   - Digits 0..3 show 3F, 6D, 00, 80.
   - Undefined: 3F, 6D, 3F, BF.
6. Assert `reset_n` = 0 with `pending` = 1.
   - Outputs go to 0 at the next edge.
   - After release, display 3F on all digits (old shadow is not committed).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: time-multiplexes DIGIT_CNT hex digits with dead time, blanking,
// blinking and tear-free frame-aligned updates. Optional leading-zero blanking: SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
   parameter int DIGIT_CNT = 8,
   parameter int SCAN_DIV  = 100000,
   parameter int DEAD_CYC  = 500,
   parameter int BLINK_DIV = 64
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   update_valid,
   output logic                   update_ready,
   input  logic [4*DIGIT_CNT-1:0] number,
   input  logic [DIGIT_CNT-1:0]   dp,
   input  logic [DIGIT_CNT-1:0]   blank_mask,
   input  logic [DIGIT_CNT-1:0]   blink_mask,
   output logic [DIGIT_CNT-1:0]   digit_sel,
   output logic [7:0]             segment
);
   localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DI_W = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
   localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
   localparam logic [SC_W-1:0] SC_DEAD = SC_W'(DEAD_CYC);
   localparam logic [DI_W-1:0] DI_LAST = DI_W'(DIGIT_CNT - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

   logic [SC_W-1:0]        sc_r;
   logic [DI_W-1:0]        di_r;
   logic [BC_W-1:0]        bc_r;
   logic                   bp_r;
   logic [4*DIGIT_CNT-1:0] shadow_num_r;
   logic [DIGIT_CNT-1:0]   shadow_dp_r;
   logic [4*DIGIT_CNT-1:0] active_num_r;
   logic [DIGIT_CNT-1:0]   active_dp_r;
   logic                   pending_r;

   logic                   slot_end_s;
   logic                   frame_end_s;
   logic                   accept_s;
   logic                   pending_nxt_s;
   logic [DIGIT_CNT-1:0]   sel_s;
   logic [3:0]             nib_s;
   logic                   dp_s;
   logic                   blank_s;
   logic                   blink_s;
   logic                   lz_s;
   logic                   dark_s;
   logic [7:0]             seg_nxt_s;

   function automatic logic [6:0] decode_hex(input logic [3:0] nib);
      case (nib)
         4'h0:    decode_hex = 7'h3F;
         4'h1:    decode_hex = 7'h06;
         4'h2:    decode_hex = 7'h5B;
         4'h3:    decode_hex = 7'h4F;
         4'h4:    decode_hex = 7'h66;
         4'h5:    decode_hex = 7'h6D;
         4'h6:    decode_hex = 7'h7D;
         4'h7:    decode_hex = 7'h07;
         4'h8:    decode_hex = 7'h7F;
         4'h9:    decode_hex = 7'h6F;
         4'hA:    decode_hex = 7'h77;
         4'hB:    decode_hex = 7'h7C;
         4'hC:    decode_hex = 7'h39;
         4'hD:    decode_hex = 7'h5E;
         4'hE:    decode_hex = 7'h79;
         4'hF:    decode_hex = 7'h71;
         default: decode_hex = 7'h00;
      endcase
   endfunction

   // Slot/frame boundaries and the handshake's next pending state
   always_comb begin
      slot_end_s  = (sc_r == SC_LAST);
      frame_end_s = slot_end_s && (di_r == DI_LAST);
      accept_s    = update_valid && update_ready;
      if (accept_s) begin
         pending_nxt_s = 1'b1;
      end else if (frame_end_s) begin
         pending_nxt_s = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end
   end

   // Scan, digit and blink counters
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sc_r <= '0;
         di_r <= '0;
         bc_r <= '0;
         bp_r <= 1'b0;
      end else begin
         if (slot_end_s) begin
            sc_r <= '0;
            di_r <= (di_r == DI_LAST) ? '0 : di_r + DI_W'(1);
         end else begin
            sc_r <= sc_r + SC_W'(1);
         end
         if (frame_end_s) begin
            if (bc_r == BC_LAST) begin
               bc_r <= '0;
               bp_r <= ~bp_r;
            end else begin
               bc_r <= bc_r + BC_W'(1);
            end
         end
      end
   end

   // Shadow capture on accept; shadow moves to active only at a frame boundary
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         shadow_num_r <= '0;
         shadow_dp_r  <= '0;
         active_num_r <= '0;
         active_dp_r  <= '0;
         pending_r    <= 1'b0;
         update_ready <= 1'b0;
      end else begin
         if (accept_s) begin
            shadow_num_r <= number;
            shadow_dp_r  <= dp;
         end
         if (frame_end_s && pending_r) begin
            active_num_r <= shadow_num_r;
            active_dp_r  <= shadow_dp_r;
         end
         pending_r    <= pending_nxt_s;
         update_ready <= ~pending_nxt_s;
      end
   end

   // Current-digit selection and segment pattern
   always_comb begin
      sel_s   = '0;
      nib_s   = 4'h0;
      dp_s    = 1'b0;
      blank_s = 1'b0;
      blink_s = 1'b0;
      for (int i = 0; i < DIGIT_CNT; i++) begin
         if (di_r == DI_W'(i)) begin
            sel_s[i] = 1'b1;
            nib_s    = active_num_r[4*i +: 4];
            dp_s     = active_dp_r[i];
            blank_s  = blank_mask[i];
            blink_s  = blink_mask[i];
         end
      end
      dark_s = (sc_r < SC_DEAD) || blank_s || (blink_s && bp_r);
      if (dark_s) begin
         seg_nxt_s = 8'h00;
      end else if (lz_s) begin
         seg_nxt_s = {dp_s, 7'h00};
      end else begin
         seg_nxt_s = {dp_s, decode_hex(nib_s)};
      end
   end

`ifdef SEG_SCAN_LZB_EN
   logic                 zero_above_s;
   logic [DIGIT_CNT-1:0] lz_vec_s;

   // A leading-zero digit keeps only its decimal point; digit 0 always shows
   always_comb begin
      zero_above_s = 1'b1;
      lz_vec_s     = '0;
      for (int i = DIGIT_CNT - 1; i >= 0; i--) begin
         zero_above_s = zero_above_s && (active_num_r[4*i +: 4] == 4'h0);
         lz_vec_s[i]  = zero_above_s && (i != 0);
      end
      lz_s = |(lz_vec_s & sel_s);
   end
`else
   assign lz_s = 1'b0;
`endif

   // Registered display outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         digit_sel <= '0;
         segment   <= 8'h00;
      end else begin
         digit_sel <= sel_s;
         segment   <= seg_nxt_s;
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: time-indexed reference model checked every cycle,
// a table of static display vectors, and hand-written handshake/reset sequences.
module tb_seg_scan_ctrl;
   localparam int DC    = 4;
   localparam int SD    = 8;
   localparam int DEAD  = 2;
   localparam int BD    = 2;
   localparam int FRAME = DC * SD;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        update_valid = 1'b0;
   logic        update_ready;
   logic [15:0] number = 16'h0000;
   logic [3:0]  dp = 4'h0;
   logic [3:0]  blank_mask = 4'h0;
   logic [3:0]  blink_mask = 4'h0;
   logic [3:0]  digit_sel;
   logic [7:0]  segment;

   seg_scan_ctrl #(.DIGIT_CNT(DC), .SCAN_DIV(SD), .DEAD_CYC(DEAD), .BLINK_DIV(BD)) dut (
      .clock(clock), .reset_n(reset_n), .update_valid(update_valid), .update_ready(update_ready),
      .number(number), .dp(dp), .blank_mask(blank_mask), .blink_mask(blink_mask),
      .digit_sel(digit_sel), .segment(segment)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference model: s counts clock edges since reset release; outputs show state s-1.
   int          s = 0;
   bit          m_pending = 1'b0;
   bit          m_ready = 1'b0;
   logic [15:0] sh_num = 16'h0, act_num = 16'h0;
   logic [3:0]  sh_dp = 4'h0, act_dp = 4'h0;
   logic [3:0]  e_sel = 4'h0;
   logic [7:0]  e_seg = 8'h00;
   bit          e_ready = 1'b0;
   logic [6:0]  dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [15:0] num;
      logic [3:0]  dpv;
      logic [3:0]  blank;
      logic [31:0] exp;   // {digit3, digit2, digit1, digit0}
   } vec_t;
   vec_t tbl [6];

   function automatic logic [7:0] exp_seg_for(int st, logic [15:0] num, logic [3:0] d,
                                              logic [3:0] bl, logic [3:0] bk);
      int sc = st % SD;
      int di = (st / SD) % DC;
      int bp = ((st / FRAME) / BD) % 2;
      logic [3:0] nib = num[di*4 +: 4];
      if (sc < DEAD || bl[di] || (bk[di] && bp == 1)) return 8'h00;
`ifdef SEG_SCAN_LZB_EN
      if (di != 0 && (num >> (4*di)) == 16'h0) return {d[di], 7'h00};
`endif
      return {d[di], dec[nib]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      if (!reset_n) begin
         e_sel = 4'h0; e_seg = 8'h00; e_ready = 1'b0;
         s = 0; m_pending = 1'b0;
         sh_num = 16'h0; sh_dp = 4'h0; act_num = 16'h0; act_dp = 4'h0;
      end else begin
         e_sel = 4'(1 << ((s / SD) % DC));
         e_seg = exp_seg_for(s, act_num, act_dp, blank_mask, blink_mask);
         if ((s % FRAME) == FRAME - 1 && m_pending) begin
            act_num = sh_num; act_dp = sh_dp; m_pending = 1'b0;
         end
         if (update_valid && m_ready) begin
            sh_num = number; sh_dp = dp; m_pending = 1'b1;
         end
         s++;
         e_ready = !m_pending;
      end
      m_ready = e_ready;
      #1;
      check("digit_sel", 32'(digit_sel), 32'(e_sel));
      check("segment", 32'(segment), 32'(e_seg));
      check("update_ready", 32'(update_ready), 32'(e_ready));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the outputs show digit d at scan count 4 (past dead time).
   task automatic seek(input int d);
      int n = 0;
      while ((((s - 1) % FRAME) != d * SD + 4) && n < 2 * FRAME) begin
         step();
         n++;
      end
      check("seek_timeout", 32'(n < 2 * FRAME), 32'd1);
   endtask

   task automatic check_digits(input string name, input logic [31:0] exp);
      for (int d = 0; d < DC; d++) begin
         seek(d);
         check(name, 32'(segment), 32'(exp[d*8 +: 8]));
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!update_ready && n < 3 * FRAME) begin
         step();
         n++;
      end
      check("ready_wait", 32'(update_ready), 32'd1);
   endtask

   task automatic offer(input logic [15:0] num, input logic [3:0] d);
      wait_ready();
      number = num; dp = d; update_valid = 1'b1;
      step();
      update_valid = 1'b0;
      check("ready_drop", 32'(update_ready), 32'd0);
   endtask

   initial begin
`ifdef SEG_SCAN_LZB_EN
      tbl[0] = '{16'h0000, 4'b0000, 4'b0000, 32'h0000_003F};
      tbl[2] = '{16'h0050, 4'b1000, 4'b0000, 32'h8000_6D3F};
`else
      tbl[0] = '{16'h0000, 4'b0000, 4'b0000, 32'h3F3F_3F3F};
      tbl[2] = '{16'h0050, 4'b1000, 4'b0000, 32'hBF3F_6D3F};
`endif
      tbl[1] = '{16'hF821, 4'b0000, 4'b0000, 32'h717F_5B06};
      tbl[3] = '{16'h1234, 4'b0101, 4'b1000, 32'h00DB_4FE6};
      tbl[4] = '{16'hABCD, 4'b0000, 4'b0000, 32'h777C_395E};
      tbl[5] = '{16'h6789, 4'b1111, 4'b0000, 32'hFD87_FFEF};

      // Reset and release with zero active value
      run(2);
      reset_n = 1'b1;
      step();
      check("rel_sel", 32'(digit_sel), 32'h1);
      check("rel_seg", 32'(segment), 32'h0);
      check("rel_ready", 32'(update_ready), 32'h1);
      run(2 * FRAME);

      // Static display vectors
      for (int r = 0; r < 6; r++) begin
         blank_mask = tbl[r].blank;
         blink_mask = 4'h0;
         offer(tbl[r].num, tbl[r].dpv);
         run(2 * FRAME);
         check_digits("table_seg", tbl[r].exp);
      end

      // Blink on digit 1, permanent blank on digit 3
      blank_mask = 4'b1000;
      blink_mask = 4'b0010;
      offer(16'h4444, 4'h0);
      run(8 * FRAME);
      blink_mask = 4'h0;
      blank_mask = 4'h0;

      // Continuous valid with a fresh number every cycle
      update_valid = 1'b1;
      for (int i = 0; i < 10 * FRAME; i++) begin
         number = 16'($urandom);
         dp = 4'($urandom);
         step();
      end
      update_valid = 1'b0;

      // Random valid, data and mask traffic
      for (int i = 0; i < 2000; i++) begin
         update_valid = ($urandom_range(0, 3) == 0);
         number = 16'($urandom);
         dp = 4'($urandom);
         if ((i % 150) == 0) begin
            blank_mask = 4'($urandom) & 4'($urandom);
            blink_mask = 4'($urandom);
         end
         step();
      end
      update_valid = 1'b0;
      blank_mask = 4'h0;
      blink_mask = 4'h0;

      // Reset while an update is pending discards the shadow
      offer(16'h0000, 4'h0);
      run(2 * FRAME);
      seek(0);
      offer(16'h9999, 4'hF);
      run(3);
      reset_n = 1'b0;
      step();
      check("rst_sel", 32'(digit_sel), 32'h0);
      check("rst_seg", 32'(segment), 32'h0);
      check("rst_ready", 32'(update_ready), 32'h0);
      reset_n = 1'b1;
      run(2 * FRAME + 4);
      check_digits("post_rst_seg", 32'h3F3F_3F3F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
